// File: rtl/tt_sweep_capture.sv
// ---------------------------------------------------------------------------
// tt_sweep_capture
//   Drives every input combination onto a combinational logic block and
//   records its single output per vector, building the measured truth table.
//   Each vector is held for SETTLE cycles and sampled in the following cycle,
//   so a vector costs SETTLE+1 cycles.
//
//   Optional build macro: TT_COMPARE_EN. It adds a reference table input and
//   match / mismatch-count outputs, which are evaluated when a sweep finishes.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        sweep request, only looked at in IDLE
//   abort        synchronous abort; returns to IDLE from any state
//   dut_in       vector driven to the block (bit N_IN-1 = first block input)
//   dut_out      block output, settled within SETTLE cycles
//   busy         high in SETTLE, SAMPLE and DONE
//   done         one-cycle pulse at sweep completion
//   table_q      captured table; bit k = dut_out observed with dut_in == k
//   table_valid  table_q holds a complete sweep
//   expected     (TT_COMPARE_EN) reference table, latched when start is taken
//   match        (TT_COMPARE_EN) captured table equals the reference
//   mismatch_cnt (TT_COMPARE_EN) number of differing table bits
// ---------------------------------------------------------------------------

// One truth-table bit: cleared when a sweep launches, loaded when its vector
// is sampled, otherwise held (so an aborted sweep keeps its partial result).
module tt_sweep_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic cap,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= 1'b0;
    else if (clr) q <= 1'b0;
    else if (cap) q <= d;
  end
endmodule

module tt_sweep_capture #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_q,
  output logic                 table_valid
`ifdef TT_COMPARE_EN
  ,
  input  logic [2**N_IN-1:0]   expected,
  output logic                 match,
  output logic [$clog2(2**N_IN):0] mismatch_cnt
`endif
);

  localparam int TBL_W = 2**N_IN;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TBL_W - 1);
  localparam logic [3:0]      CNT_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  // With no settle time every vector goes straight to its sample cycle.
  localparam state_t          S_VEC    = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  state_t          state, state_n;
  logic [N_IN-1:0] idx, idx_n;
  logic [3:0]      cnt, cnt_n;
  logic            launch;   // start accepted this cycle
  logic            capture;  // sample dut_out into table_q[idx]
  logic            finish;   // leaving DONE normally

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    launch  = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    if (abort) begin
      state_n = S_IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            launch  = 1'b1;
            idx_n   = '0;
            cnt_n   = '0;
            state_n = S_VEC;
          end
        end
        S_SETTLE: begin
          if (cnt == CNT_LAST) state_n = S_SAMPLE;
          else                 cnt_n   = cnt + 4'd1;
        end
        S_SAMPLE: begin
          capture = 1'b1;
          if (idx == IDX_LAST) begin
            state_n = S_DONE;
          end else begin
            idx_n   = idx + 1'b1;
            cnt_n   = '0;
            state_n = S_VEC;
          end
        end
        S_DONE: begin
          finish  = 1'b1;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Outputs are flops loaded from next-state values so they line up with the
  // state they describe and never see dut_out combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      cnt         <= '0;
      dut_in      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      table_valid <= 1'b0;
    end else begin
      idx    <= idx_n;
      cnt    <= cnt_n;
      busy   <= (state_n != S_IDLE);
      done   <= (state_n == S_DONE);
      dut_in <= (state_n == S_SETTLE || state_n == S_SAMPLE) ? idx_n : '0;
      if (launch)      table_valid <= 1'b0;
      else if (finish) table_valid <= 1'b1;
    end
  end

  for (genvar i = 0; i < TBL_W; i++) begin : g_cell
    tt_sweep_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (launch),
      .cap   (capture && (idx == N_IN'(i))),
      .d     (dut_out),
      .q     (table_q[i])
    );
  end

`ifdef TT_COMPARE_EN
  localparam int CW = $clog2(TBL_W) + 1;

  logic [TBL_W-1:0] exp_q;
  logic [TBL_W-1:0] diff;
  logic [CW-1:0]    pop;

  always_comb begin
    diff = table_q ^ exp_q;
    pop  = '0;
    for (int i = 0; i < TBL_W; i++) pop = pop + CW'(diff[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q        <= '0;
      match        <= 1'b0;
      mismatch_cnt <= '0;
    end else if (launch) begin
      exp_q        <= expected;
      match        <= 1'b0;
      mismatch_cnt <= '0;
    end else if (finish) begin
      match        <= (table_q == exp_q);
      mismatch_cnt <= pop;
    end
  end
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// ---------------------------------------------------------------------------
// tb_tt_sweep_capture
//   Randomized bench for tt_sweep_capture (SETTLE=2 main instance plus a
//   SETTLE=0 instance). A timeline model derives every expected output from
//   the cycle offset since the accepted start; sweeps are queued on a
//   scoreboard when issued and popped by the monitor whenever done pulses.
//   Build with TT_COMPARE_EN defined to exercise the compare outputs.
// ---------------------------------------------------------------------------
module tb_tt_sweep_capture;
  localparam int NV    = 16;
  localparam int S     = 2;
  localparam int PER   = S + 1;
  localparam int SWEEP = NV * PER;   // edges from accept to entering DONE

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [3:0]  dut_in;
  logic        dut_out, busy, done, table_valid;
  logic [15:0] table_q;
  logic [15:0] truth = 16'h0;
  assign dut_out = truth[dut_in];

  logic        start0 = 1'b0, abort0 = 1'b0;
  logic [3:0]  dut_in0;
  logic        dut_out0, busy0, done0, tv0;
  logic [15:0] tq0;
  logic [15:0] truth0 = 16'hFFFF;
  assign dut_out0 = truth0[dut_in0];

`ifdef TT_COMPARE_EN
  logic [15:0] expected = 16'h0, expected0 = 16'h0;
  logic        match, match0;
  logic [4:0]  mismatch_cnt, mismatch_cnt0;
`endif

  always #5 clk = ~clk;

  tt_sweep_capture #(.N_IN(4), .SETTLE(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_in(dut_in),
    .dut_out(dut_out), .busy(busy), .done(done), .table_q(table_q),
    .table_valid(table_valid)
`ifdef TT_COMPARE_EN
    , .expected(expected), .match(match), .mismatch_cnt(mismatch_cnt)
`endif
  );

  tt_sweep_capture #(.N_IN(4), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .dut_in(dut_in0),
    .dut_out(dut_out0), .busy(busy0), .done(done0), .table_q(tq0),
    .table_valid(tv0)
`ifdef TT_COMPARE_EN
    , .expected(expected0), .match(match0), .mismatch_cnt(mismatch_cnt0)
`endif
  );

  int vectors = 0, miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed { logic [15:0] tbl; int e0; } exp_t;
  exp_t        sbq[$];
  int          cyc = 0, m_e0 = 0;
  bit          m_active = 0, m_valid = 0, m_pending = 0, m_match = 0;
  logic [15:0] m_table = '0, m_exp = '0;
  int          m_mcnt = 0;

  always @(posedge clk or negedge rst_n) begin : model
    int t;
    if (!rst_n) begin
      if (m_pending) sbq.delete(sbq.size() - 1);
      m_pending = 0; m_active = 0; m_valid = 0; m_table = '0;
      m_match = 0; m_mcnt = 0; m_exp = '0;
    end else begin
      cyc++;
      if (abort) begin
        if (m_pending) sbq.delete(sbq.size() - 1);
        m_pending = 0;
        m_active  = 0;
      end else if (m_active) begin
        t = cyc - m_e0;
        if (t <= SWEEP && (t % PER) == 0) m_table[t/PER - 1] = truth[t/PER - 1];
        if (t == SWEEP + 1) begin
          m_active = 0;
          m_valid  = 1;
          m_match  = (m_table == m_exp);
          m_mcnt   = $countones(m_table ^ m_exp);
        end
      end else if (start) begin
        m_active = 1; m_e0 = cyc; m_table = '0; m_valid = 0;
        m_match = 0; m_mcnt = 0;
`ifdef TT_COMPARE_EN
        m_exp = expected;
`endif
        sbq.push_back('{tbl: truth, e0: cyc});
        m_pending = 1;
      end
    end
  end

  always @(negedge clk) begin : monitor
    int t;
    exp_t e;
    t = cyc - m_e0;
    chk("busy", busy, m_active);
    chk("done", done, m_active && t == SWEEP);
    chk("dut_in", dut_in, (m_active && t < SWEEP) ? t / PER : 0);
    chk("table_q", table_q, m_table);
    chk("table_valid", table_valid, m_valid);
`ifdef TT_COMPARE_EN
    chk("match", match, m_match);
    chk("mismatch_cnt", mismatch_cnt, m_mcnt);
`endif
    if (done === 1'b1) begin
      if (sbq.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        e = sbq.pop_front();
        m_pending = 0;
        chk("sweep_table", table_q, e.tbl);
        chk("done_cycle", cyc - e.e0 + 1, SWEEP + 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle(input int lim);
    int n = 0;
    while (m_active && n < lim) begin @(negedge clk); n++; end
    if (m_active) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_sweep(input logic [15:0] tt, input int abort_at);
    truth = tt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (abort_at >= 0) begin
      repeat (abort_at) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    wait_idle(200);
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, old_e0, bad, c;
    #1;
    chk("rst_dut_in", dut_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_table", table_q, 0);
    chk("rst_valid", table_valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ones at vectors 11, 13, 14
    run_sweep(16'h6800, -1);
    chk("tt_6800", table_q, 16'h6800);
    chk("tt_6800_valid", table_valid, 1);

    for (int i = 0; i < 3; i++) run_sweep(16'($urandom), -1);

    // abort while vector 7 is applied
    truth = 16'hFFFF;
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0;
    while (dut_in != 4'd7 && n < 100) begin @(negedge clk); n++; end
    chk("reach_idx7", dut_in, 7);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_dut_in", dut_in, 0);
    chk("abort_upper", table_q[15:7], 0);
    chk("abort_lower", table_q[6:0], 7'h7F);
    repeat (2) @(negedge clk);

    // start pulsed mid-sweep, then held high across DONE
    truth = 16'($urandom);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    old_e0 = m_e0;
    start = 1'b1;
    n = 0;
    while (m_e0 == old_e0 && n < 100) begin @(negedge clk); n++; end
    start = 1'b0;
    chk("relaunch_seen", (m_e0 != old_e0), 1);
    wait_idle(200);

    // async reset in a SAMPLE cycle
    truth = 16'($urandom);
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0;
    while (!(dut_in == 4'd5 && ((cyc - m_e0) % PER) == PER - 1) && n < 100) begin
      @(negedge clk); n++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_dut_in", dut_in, 0);
    chk("arst_done", done, 0);
    chk("arst_table", table_q, 0);
    chk("arst_valid", table_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(16'($urandom), -1);

`ifdef TT_COMPARE_EN
    expected = 16'h6800;
    run_sweep(16'h6801, -1);
    chk("cmp_bad_match", match, 0);
    chk("cmp_bad_cnt", mismatch_cnt, 1);
    run_sweep(16'h6800, -1);
    chk("cmp_ok_match", match, 1);
    chk("cmp_ok_cnt", mismatch_cnt, 0);
`endif

    // randomized sweeps with occasional aborts
    for (int i = 0; i < 8; i++) begin
`ifdef TT_COMPARE_EN
      expected = ($urandom_range(0, 1) == 0) ? truth : 16'($urandom);
`endif
      run_sweep(16'($urandom),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, SWEEP + 1)) : -1);
    end
    wait_idle(200);
    chk("sb_leftover", sbq.size(), 0);

    // SETTLE=0 instance: one vector per cycle
    for (int r = 0; r < 2; r++) begin
      truth0 = (r == 0) ? 16'hFFFF : 16'($urandom);
      start0 = 1'b1; @(negedge clk); start0 = 1'b0;
      bad = 0; c = 1;
      while (done0 !== 1'b1 && c < 40) begin
        if (c <= NV && dut_in0 != 4'(c - 1)) bad++;
        @(negedge clk); c++;
      end
      chk("s0_steps", bad, 0);
      chk("s0_done_cycle", c, NV + 1);
      chk("s0_table", tq0, truth0);
      @(negedge clk);
      chk("s0_valid", tv0, 1);
      chk("s0_busy", busy0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
